// File: rtl/fifo_prm_pkg.sv
// Shared definitions for the parametrised flop FIFO: a constant clog2 helper,
// the type used for derived width parameters, the push/pop operation encoding
// and the bit positions of the optional sticky error flags
// (enabled by defining FIFO_ERR_FLAGS_EN).
package fifo_prm_pkg;

  // Type of width parameters derived from depth (count and pointer widths).
  typedef int unsigned cnt_width_t;

  // Accepted operation for one clock; bit 0 = push accepted, bit 1 = pop accepted.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Bit positions inside the sticky error register.
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UDF_BIT = 1;
  localparam int ERR_W       = 2;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic cnt_width_t clog2(input int unsigned value);
    int unsigned v;
    cnt_width_t  r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and occupancy control for fifo_flops_prm: decides which of push/pop
// are accepted this cycle, keeps the read/write pointers (explicit wrap at
// depth-1, so any depth works) and the occupancy count.
module fifo_ptr_ctrl
  import fifo_prm_pkg::*;
#(
  parameter int         depth = 8,
  parameter cnt_width_t CW    = clog2(depth + 1),
  parameter cnt_width_t AW    = clog2(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] count
);

  localparam logic [AW-1:0] LAST_PTR = AW'(depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic     empty;
  logic     full;
  logic     do_push;
  logic     do_pop;
  fifo_op_e op;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  // Acceptance: a pop frees a slot for a same-cycle push when full; an empty
  // FIFO never bypasses, so a push+pop on empty is treated as push only.
  // NOTE: every output of an always_comb gets a value on every path (here by
  // straight-line assignment) so no latch is inferred.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    op      = fifo_op_e'({do_pop, do_push});
  end

  // The write strobe is masked during reset so no write lands while contents
  // are being discarded.
  assign wr_en = do_push && !rst;

  // Pointer and count state, discarded immediately on reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
      count   <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_addr <= ptr_inc(wr_addr);
          count   <= count + CW'(1);
        end
        OP_POP: begin
          rd_addr <= ptr_inc(rd_addr);
          count   <= count - CW'(1);
        end
        OP_BOTH: begin
          wr_addr <= ptr_inc(wr_addr);
          rd_addr <= ptr_inc(rd_addr);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_flops_prm.sv
// Parametrised flop-based synchronous FIFO, first-word-fall-through, with
// occupancy count and almost-full/almost-empty thresholds. Superset of the
// legacy Din/Dout/push/pop/full/pndng port set.
// Optional: define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_flops_prm
  import fifo_prm_pkg::*;
#(
  parameter int bits  = 16,
  parameter int depth = 8,
  parameter int AF_TH = 6,
  parameter int AE_TH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [bits-1:0]             Din,
  input  logic                        push,
  input  logic                        pop,
  output logic [bits-1:0]             Dout,
  output logic                        full,
  output logic                        pndng,
  output logic [clog2(depth+1)-1:0]   count,
  output logic                        almost_full,
  output logic                        almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                        overflow,
  output logic                        underflow
`endif
);

  localparam cnt_width_t      CW       = clog2(depth + 1);
  localparam cnt_width_t      AW       = clog2(depth);
  localparam logic [CW-1:0]   FULL_CNT = CW'(depth);
  localparam logic [CW-1:0]   AF_CNT   = CW'(AF_TH);
  localparam logic [CW-1:0]   AE_CNT   = CW'(AE_TH);

  // Elaboration-time parameter sanity checks.
  if (depth < 2) begin : g_bad_depth
    $fatal(1, "fifo_flops_prm: depth must be >= 2");
  end
  if (bits < 1) begin : g_bad_bits
    $fatal(1, "fifo_flops_prm: bits must be >= 1");
  end
  if (AF_TH < 1 || AF_TH > depth) begin : g_bad_af
    $fatal(1, "fifo_flops_prm: AF_TH must be in 1..depth");
  end
  if (AE_TH < 0 || AE_TH >= depth) begin : g_bad_ae
    $fatal(1, "fifo_flops_prm: AE_TH must be in 0..depth-1");
  end

  logic [bits-1:0] mem [depth];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;

  fifo_ptr_ctrl #(
    .depth (depth),
    .CW    (CW),
    .AW    (AW)
  ) u_ptr_ctrl (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .count   (count)
  );

  // Storage write.
  // NOTE: the storage array has no reset; validity is tracked by count alone,
  // which keeps it a plain register file with no reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= Din;
    end
  end

  // Head-of-queue output and flag decode, all derived from registered state.
  always_comb begin
    pndng        = (count != '0);
    full         = (count == FULL_CNT);
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
    Dout         = pndng ? mem[rd_addr] : '0;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic [ERR_W-1:0] err_q;
  logic             ovf_evt;
  logic             udf_evt;

  // A dropped push needs full with no companion pop; any pop on empty counts.
  always_comb begin
    ovf_evt = push && !pop && full;
    udf_evt = pop && !pndng;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      if (ovf_evt) err_q[ERR_OVF_BIT] <= 1'b1;
      if (udf_evt) err_q[ERR_UDF_BIT] <= 1'b1;
    end
  end

  assign overflow  = err_q[ERR_OVF_BIT];
  assign underflow = err_q[ERR_UDF_BIT];
`endif

endmodule

// File: tb/tb_fifo_flops_prm.sv
// Directed bench for fifo_flops_prm: a depth-8 instance for reset, fill,
// full/empty corner cases and (with FIFO_ERR_FLAGS_EN) the sticky error
// flags, plus a depth-5 instance for non-power-of-two pointer wrap.
module tb_fifo_flops_prm;

  logic        clk;
  logic        rst;

  // depth 8 instance
  logic [15:0] din;
  logic        push;
  logic        pop;
  logic [15:0] dout;
  logic        full;
  logic        pndng;
  logic [3:0]  count;
  logic        af;
  logic        ae;

  // depth 5 instance
  logic [15:0] din5;
  logic        push5;
  logic        pop5;
  logic [15:0] dout5;
  logic        full5;
  logic        pndng5;
  logic [2:0]  count5;
  logic        af5;
  logic        ae5;

`ifdef FIFO_ERR_FLAGS_EN
  logic        ovf;
  logic        udf;
  logic        ovf5;
  logic        udf5;
`endif

  int errors = 0;
  int checks = 0;

  fifo_flops_prm #(.bits(16), .depth(8), .AF_TH(6), .AE_TH(2)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .Din          (din),
    .push         (push),
    .pop          (pop),
    .Dout         (dout),
    .full         (full),
    .pndng        (pndng),
    .count        (count),
    .almost_full  (af),
    .almost_empty (ae)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow     (ovf),
    .underflow    (udf)
`endif
  );

  fifo_flops_prm #(.bits(16), .depth(5), .AF_TH(4), .AE_TH(1)) u_dut5 (
    .clk          (clk),
    .rst          (rst),
    .Din          (din5),
    .push         (push5),
    .pop          (pop5),
    .Dout         (dout5),
    .full         (full5),
    .pndng        (pndng5),
    .count        (count5),
    .almost_full  (af5),
    .almost_empty (ae5)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow     (ovf5),
    .underflow    (udf5)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock on the depth-8 instance; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic [15:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic step5(input logic p, input logic q, input logic [15:0] d);
    push5 = p;
    pop5  = q;
    din5  = d;
    @(posedge clk);
    #1;
    push5 = 1'b0;
    pop5  = 1'b0;
  endtask

  initial begin
    push = 0; pop = 0; din = '0;
    push5 = 0; pop5 = 0; din5 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_pndng", 32'(pndng), 0);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(af), 0);
    check("rst_ae", 32'(ae), 1);
    check("rst_dout", 32'(dout), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1. async reset in the middle of traffic with five entries queued
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0011 + 16'(i));
    check("mid_count5", 32'(count), 5);
    check("mid_dout", 32'(dout), 32'h11);
    #2 rst = 1'b1;
    #1;
    check("async_count", 32'(count), 0);
    check("async_pndng", 32'(pndng), 0);
    check("async_ae", 32'(ae), 1);
    check("async_dout", 32'(dout), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 16'hA5A5);
    check("post_rst_dout", 32'(dout), 32'hA5A5);
    check("post_rst_count", 32'(count), 1);
    step(1'b0, 1'b1, 16'h0000);
    check("post_rst_empty", 32'(pndng), 0);

    // 2. fill to full, threshold flags at every level, dropped 9th push
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 16'(i));
      check($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
      check($sformatf("fill_af_%0d", i), 32'(af), (i >= 6) ? 1 : 0);
      check($sformatf("fill_ae_%0d", i), 32'(ae), (i <= 2) ? 1 : 0);
    end
    check("full_flag", 32'(full), 1);
    step(1'b1, 1'b0, 16'hFFFF);
    check("drop_count", 32'(count), 8);
    check("drop_head", 32'(dout), 1);
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_set", 32'(ovf), 1);
    check("udf_clear", 32'(udf), 0);
`endif
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_dout_%0d", i), 32'(dout), 32'(i));
      step(1'b0, 1'b1, 16'h0000);
    end
    check("drain_pndng", 32'(pndng), 0);
    check("drain_dout0", 32'(dout), 0);
    step(1'b0, 1'b1, 16'h0000);
    check("pop_empty_count", 32'(count), 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("udf_set", 32'(udf), 1);
    step(1'b0, 1'b0, 16'h0000);
    check("udf_held", 32'(udf), 1);
    check("ovf_held", 32'(ovf), 1);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_rst", 32'(ovf), 0);
    check("udf_rst", 32'(udf), 0);
`endif

    // 3. push+pop together while full
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i));
    check("full_again", 32'(full), 1);
    check("both_full_head", 32'(dout), 1);
    step(1'b1, 1'b1, 16'h0009);
    check("both_full_count", 32'(count), 8);
    check("both_full_next", 32'(dout), 2);
`ifdef FIFO_ERR_FLAGS_EN
    check("both_full_no_ovf", 32'(ovf), 0);
`endif
    for (int i = 2; i <= 9; i++) begin
      check($sformatf("both_drain_%0d", i), 32'(dout), 32'(i));
      step(1'b0, 1'b1, 16'h0000);
    end
    check("both_drain_empty", 32'(count), 0);

    // 4. push+pop together while empty: push only
    step(1'b1, 1'b1, 16'h1234);
    check("both_empty_count", 32'(count), 1);
    check("both_empty_dout", 32'(dout), 32'h1234);
`ifdef FIFO_ERR_FLAGS_EN
    check("both_empty_udf", 32'(udf), 1);
`endif
    step(1'b0, 1'b1, 16'h0000);
    check("both_empty_drain", 32'(pndng), 0);

    // 5. depth-5 wrap: hold count at 3 through 12 push/pop pairs
    for (int i = 0; i < 3; i++) step5(1'b1, 1'b0, 16'h0100 + 16'(i));
    check("d5_count3", 32'(count5), 3);
    check("d5_ae", 32'(ae5), 0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("d5_head_%0d", i), 32'(dout5), 32'h100 + 32'(i));
      step5(1'b1, 1'b1, 16'h0103 + 16'(i));
      check($sformatf("d5_count_%0d", i), 32'(count5), 3);
    end
    for (int i = 12; i < 15; i++) begin
      check($sformatf("d5_tail_%0d", i), 32'(dout5), 32'h100 + 32'(i));
      step5(1'b0, 1'b1, 16'h0000);
    end
    check("d5_empty", 32'(count5), 0);
    check("d5_dout0", 32'(dout5), 0);
    for (int i = 0; i < 5; i++) step5(1'b1, 1'b0, 16'h0200 + 16'(i));
    check("d5_full", 32'(full5), 1);
    check("d5_af", 32'(af5), 1);
    check("d5_full_head", 32'(dout5), 32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_flops_prm.md
Name: fifo_flops_prm

Overview:
Parametrised next-generation flop-based synchronous FIFO with first-word-fall-through output, occupancy count and almost-full/almost-empty thresholds. Drop-in superset of the existing flop FIFO port set (Din/Dout/push/pop/full/pndng). Sits between a producer agent and a consumer in the same clock domain. Used by the transaction-level bench for threshold and error-path testing.

Parameters:
bits, 16, data word width (>=1)
depth, 8, number of entries (>=2, any integer, not limited to a power of two)
AF_TH, 6, almost_full asserted when count >= AF_TH (1..depth)
AE_TH, 2, almost_empty asserted when count <= AE_TH (0..depth-1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
Din  in  bits  write data, sampled on push
push  in  1  write request
pop  in  1  read request; consumes the word currently on Dout
Dout  out  bits  head-of-queue word (FWFT); 0 when empty
full  out  1  count == depth
pndng  out  1  count != 0
count  out  $clog2(depth+1)  current occupancy
almost_full  out  1  count >= AF_TH
almost_empty  out  1  count <= AE_TH

Behaviour:
- Reset (async assert, sync release on clk): wr_ptr=rd_ptr=0, count=0, storage not cleared; outputs Dout=0, full=0, pndng=0, count=0, almost_full=0, almost_empty=1.
- Reset mid-operation discards all contents immediately; no partial write completes.
- All flags and count are registered-state derived (combinational from count), valid the cycle after the causing edge.
- Dout = mem[rd_ptr] when pndng=1, else 0; no read latency. A pushed word is visible on Dout the cycle after the push edge.
- Pointers are 0..depth-1 and wrap explicitly (ptr==depth-1 -> 0); there is no power-of-two masking.
- push only, not full: write Din at wr_ptr, wr_ptr++, count++.
- push only, full: write dropped, state unchanged.
- pop only, not empty: rd_ptr++, count--.
- pop only, empty: ignored, state unchanged.
- push+pop, 0<count<depth: both performed, count unchanged.
- push+pop, full: pop performed and the write accepted into the freed slot; count stays depth.
- push+pop, empty: push performed, pop ignored (no bypass); count becomes 1.
- Parameter checks at elaboration: AF_TH in 1..depth and AE_TH < depth; otherwise $fatal.

Optional Feature:
FIFO_ERR_FLAGS_EN:
- Defined: adds outputs overflow and underflow (1 bit each), sticky, reset to 0 by rst only. overflow sets on push while full without pop. underflow sets on pop while empty.
- Not defined: these ports do not exist; dropped pushes and ignored pops are silent.

Decomposition:
- Package fifo_prm_pkg: function clog2 helper, typedef for the count type width, and the error-flag bit positions.
- Sub-module fifo_ptr_ctrl: owns the pointers, count, wrap logic and push/pop acceptance. Outputs wr_en, wr_addr, rd_addr and count.
- The top level holds the storage array, Dout mux, flag decode and optional error flags.

Test Plan:
1. rst=1 mid-stream with count=5 -> the same cycle count=0, pndng=0, almost_empty=1, Dout=0; after release, push 0xA5A5 -> Dout=0xA5A5 the next cycle.
2. Push 8 words 0x0001..0x0008 (depth=8) -> full=1, count=8, almost_full from count=6. A 9th push of 0xFFFF is dropped; pop order is 0x0001..0x0008, with no 0xFFFF.
3. With full, push 0x0009 and pop together -> popped 0x0001, count=8, last popped word later is 0x0009.
4. With empty, push 0x1234 and pop together -> count=1, Dout=0x1234 the next cycle.
5. depth=5 build: 12 push/pop pairs at count=3 -> the pointers wrap correctly and the data sequence is preserved.
6. With FIFO_ERR_FLAGS_EN: pop on empty -> underflow=1 and held; push on full -> overflow=1; both clear only on rst.
